// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit memory controller.
package lsu_pkg;

    // Access size encoding as presented by the execute stage; 2'b11 is illegal.
    typedef enum logic [1:0] {
        SZ_B = 2'b00,
        SZ_H = 2'b01,
        SZ_W = 2'b10
    } size_e;

    // Controller states.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RD    = 3'd1,
        DATA  = 3'd2,
        MERGE = 3'd3,
        WR    = 3'd4,
        RESP  = 3'd5
    } lsu_state_e;

    // Natural alignment check: halfwords on even addresses, words on multiples of four.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic mis;
        mis = 1'b0;
        if (size == SZ_H) begin
            mis = addr_lo[0];
        end else if (size == SZ_W) begin
            mis = (addr_lo != 2'b00);
        end
        return mis;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane steering between a 32-bit memory word and byte/half/word accesses.
// Produces the extended load value and the read-modify-write store word.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [1:0]  size_i,
    input  logic        uns_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] load_o,
    output logic [31:0] merge_o
);

    logic [4:0]  shamt;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] byte_mask;
    logic [31:0] byte_ins;

    // Select the addressed lane, extend it, and splice store data into the word.
    always_comb begin
        shamt     = {addr_lo_i, 3'b000};
        byte_sel  = 8'(word_i >> shamt);
        half_sel  = addr_lo_i[1] ? word_i[31:16] : word_i[15:0];
        byte_mask = 32'h0000_00FF << shamt;
        byte_ins  = {24'b0, wdata_i[7:0]} << shamt;
        load_o    = word_i;
        merge_o   = wdata_i;
        case (size_i)
            SZ_B: begin
                load_o  = {{24{byte_sel[7] & ~uns_i}}, byte_sel};
                merge_o = (word_i & ~byte_mask) | byte_ins;
            end
            SZ_H: begin
                load_o  = {{16{half_sel[15] & ~uns_i}}, half_sel};
                merge_o = addr_lo_i[1] ? {wdata_i[15:0], word_i[15:0]}
                                       : {word_i[31:16], wdata_i[15:0]};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store controller in front of a word-only data memory. Sub-word
// stores are done as read-modify-write; loads are lane-selected and extended.
module lsu_mem_ctrl
    import lsu_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DEPTH_WORDS = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic              mem_wr_en,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_address,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    // One extra bit so the limit is representable even when it equals 2**ADDR_W.
    localparam logic [ADDR_W:0] ADDR_LIMIT = (ADDR_W+1)'(DEPTH_WORDS) << 2;

    lsu_state_e        state_q, state_d;
    logic              we_q, we_d;
    logic [1:0]        size_q, size_d;
    logic              uns_q, uns_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              err_q, err_d;
    logic [31:0]       rdata_q, rdata_d;

    logic              req_err;
    logic [31:0]       load_val;
    logic [31:0]       merge_val;

    assign req_err = (req_size == 2'b11)
                  || is_misaligned(req_size, req_addr[1:0])
                  || ({1'b0, req_addr} >= ADDR_LIMIT);

    // The memory port always sees the word containing the latched address.
    assign mem_address = {addr_q[ADDR_W-1:2], 2'b00};

    lsu_align u_align (
        .word_i    (mem_rdata),
        .addr_lo_i (addr_q[1:0]),
        .size_i    (size_q),
        .uns_i     (uns_q),
        .wdata_i   (wdata_q),
        .load_o    (load_val),
        .merge_o   (merge_val)
    );

    // State and request registers; reset also kills any write strobe instantly.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            size_q  <= 2'b00;
            uns_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= 32'h0;
            err_q   <= 1'b0;
            rdata_q <= 32'h0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    // Next-state logic and Moore outputs for the access sequence.
    always_comb begin
        state_d    = state_q;
        we_d       = we_q;
        size_d     = size_q;
        uns_d      = uns_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        err_d      = err_q;
        rdata_d    = rdata_q;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        resp_rdata = 32'h0;
        resp_err   = 1'b0;
        mem_wr_en  = 1'b0;
        mem_rd_en  = 1'b0;
        mem_wdata  = 32'h0;
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    we_d    = req_we;
                    size_d  = req_size;
                    uns_d   = req_unsigned;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    err_d   = req_err;
                    rdata_d = 32'h0;
                    if (req_err) begin
                        state_d = RESP;
                    end else if (req_we && (req_size == SZ_W)) begin
                        state_d = WR;
                    end else begin
                        state_d = RD;
                    end
                end
            end
            RD: begin
                mem_rd_en = 1'b1;
                state_d   = we_q ? MERGE : DATA;
            end
            DATA: begin
                rdata_d = load_val;
                state_d = RESP;
            end
            MERGE: begin
                mem_wr_en = 1'b1;
                mem_wdata = merge_val;
                state_d   = RESP;
            end
            WR: begin
                mem_wr_en = 1'b1;
                mem_wdata = wdata_q;
                state_d   = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                resp_rdata = rdata_q;
                resp_err   = err_q;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule
